// File: rtl/imem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_arbiter : shares the single-port instruction SRAM between the IF    |
// |                fetch port and the debug monitor, LAT-cycle accesses.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imem_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 14
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst_n,
  input  logic          if_ce,
  input  logic [31:0]   if_pc,
  output logic [31:0]   if_instr,
  output logic          if_valid,
  output logic          if_stall_req,
  input  logic          mon_req,
  input  logic          mon_we,
  input  logic [31:0]   mon_addr,
  input  logic [31:0]   mon_wdata,
  output logic          mon_ack,
  output logic [31:0]   mon_rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               owner_mon_q;
  logic               last_mon_q;
  logic               mon_wr_q;
  logic [31:0]        pc_q;
  logic               sram_ce_q;
  logic               sram_we_q;
  logic [AW-1:0]      sram_addr_q;
  logic [31:0]        sram_wdata_q;
  logic [31:0]        if_instr_q;
  logic               if_valid_q;
  logic               mon_ack_q;
  logic [31:0]        mon_rdata_q;

  logic               grant_mon;
  logic               grant_if;
  logic               unused_addr_bits;

  // Round-robin on contention: the monitor yields once it has had the last turn.
  assign grant_mon = mon_req & (~if_ce | ~last_mon_q);
  assign grant_if  = if_ce & ~grant_mon;

  assign unused_addr_bits = ^{mon_addr[31:AW+2], mon_addr[1:0]};

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_mon_q  <= 1'b0;
      last_mon_q   <= 1'b0;
      mon_wr_q     <= 1'b0;
      pc_q         <= '0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_instr_q   <= '0;
      if_valid_q   <= 1'b0;
      mon_ack_q    <= 1'b0;
      mon_rdata_q  <= '0;
    end else begin
      sram_ce_q  <= 1'b0;
      sram_we_q  <= 1'b0;
      if_valid_q <= 1'b0;
      mon_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mon || grant_if) begin
            state_q      <= ACC;
            cnt_q        <= CNT_W'(LAT);
            owner_mon_q  <= grant_mon;
            last_mon_q   <= grant_mon;
            mon_wr_q     <= grant_mon & mon_we;
            sram_ce_q    <= 1'b1;
            sram_we_q    <= grant_mon & mon_we;
            sram_wdata_q <= mon_wdata;
            sram_addr_q  <= grant_mon ? mon_addr[AW+1:2] : if_pc[AW+1:2];
            if (grant_if) begin
              pc_q <= if_pc;
            end
          end
        end
        ACC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (owner_mon_q) begin
              if (!mon_wr_q) begin
                mon_rdata_q <= sram_rdata;
              end
              mon_ack_q <= 1'b1;
              state_q   <= RESP;
            end else if (if_ce && (if_pc == pc_q)) begin
              if_instr_q <= sram_rdata;
              if_valid_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              // Fetch was withdrawn or redirected: drop the stale word.
              state_q <= IDLE;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_instr     = if_instr_q;
  assign if_valid     = if_valid_q;
  assign if_stall_req = if_ce & ~if_valid_q & cpu_rst_n;
  assign mon_ack      = mon_ack_q;
  assign mon_rdata    = mon_rdata_q;
  assign sram_ce      = sram_ce_q;
  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// tb_imem_arbiter : directed + randomized bench, checked every cycle against a
// transaction-phase reference model; a second LAT=1 instance covers pipelining.
module tb_imem_arbiter;

  localparam int LAT   = 2;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_ce, if_valid, if_stall_req;
  logic [31:0]   if_pc, if_instr;
  logic          mon_req, mon_we, mon_ack;
  logic [31:0]   mon_addr, mon_wdata, mon_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;

  logic          if_ce1, if_valid1, if_stall1, mon_ack1, sram_ce1, sram_we1;
  logic [31:0]   if_pc1, if_instr1, unused_rdata1, unused_wdata1, sram_rdata1;
  logic [AW-1:0] sram_addr1;

  imem_arbiter #(.LAT(LAT), .AW(AW)) u_dut (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .if_ce(if_ce), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .if_stall_req(if_stall_req),
    .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
    .mon_ack(mon_ack), .mon_rdata(mon_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  imem_arbiter #(.LAT(1), .AW(AW)) u_dut1 (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .if_ce(if_ce1), .if_pc(if_pc1), .if_instr(if_instr1), .if_valid(if_valid1),
    .if_stall_req(if_stall1),
    .mon_req(1'b0), .mon_we(1'b0), .mon_addr(32'h0), .mon_wdata(32'h0),
    .mon_ack(mon_ack1), .mon_rdata(unused_rdata1),
    .sram_ce(sram_ce1), .sram_we(sram_we1), .sram_addr(sram_addr1),
    .sram_wdata(unused_wdata1), .sram_rdata(sram_rdata1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h2402_0005 : (32'hC0DE_0000 | 32'(i));
  endfunction

  // SRAM: read data is only valid exactly LAT-1 cycles after the ce cycle.
  // Contents reload on reset so memory and reference restart together.
  logic [31:0] mem [DEPTH];
  int since_ce;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since_ce <= 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    end else begin
      if (sram_ce && sram_we) mem[sram_addr] = sram_wdata;
      since_ce <= sram_ce ? 1 : ((since_ce != 0 && since_ce < 8) ? since_ce + 1 : 0);
    end
  end
  assign sram_rdata  = ((sram_ce || since_ce != 0) && ((sram_ce ? 0 : since_ce) == LAT - 1))
                       ? mem[sram_addr] : 32'hBAD0_BAD0;
  assign sram_rdata1 = sram_ce1 ? mem[sram_addr1] : 32'hBAD1_BAD1;

  // Reference model: t = cycles into the current access (0 idle, 1..LAT
  // SRAM access, LAT+1 response cycle).
  logic [31:0]   ref_mem [DEPTH];
  int            t;
  bit            m_mon, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_pc, m_instr, m_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_mon = 0; m_we = 0; m_last = 0;
      m_addr = '0; m_wdata = '0; m_pc = '0; m_instr = '0; m_rdata = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    end else if (t == 0) begin
      if (mon_req || if_ce) begin
        m_mon   = mon_req && !(if_ce && m_last);
        m_last  = m_mon;
        m_we    = m_mon && mon_we;
        m_addr  = m_mon ? mon_addr[AW+1:2] : if_pc[AW+1:2];
        m_wdata = mon_wdata;
        m_pc    = if_pc;
        t       = 1;
      end
    end else begin
      if (t == 1 && m_we) ref_mem[m_addr] = m_wdata;
      if (t < LAT) t = t + 1;
      else if (t == LAT) begin
        if (m_mon) begin
          if (!m_we) m_rdata = ref_mem[m_addr];
          t = LAT + 1;
        end else if (if_ce && if_pc == m_pc) begin
          m_instr = ref_mem[m_addr];
          t = LAT + 1;
        end else t = 0;
      end else t = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("sram_ce",      32'(sram_ce),      32'(t == 1));
      check_eq("sram_we",      32'(sram_we),      32'(t == 1 && m_we));
      check_eq("if_valid",     32'(if_valid),     32'(t == LAT + 1 && !m_mon));
      check_eq("mon_ack",      32'(mon_ack),      32'(t == LAT + 1 && m_mon));
      check_eq("if_stall_req", 32'(if_stall_req), 32'(if_ce && !(t == LAT + 1 && !m_mon)));
      check_eq("if_instr",     if_instr,          m_instr);
      check_eq("mon_rdata",    mon_rdata,         m_rdata);
      if (t >= 1 && t <= LAT) begin
        check_eq("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (m_we) check_eq("sram_wdata", sram_wdata, m_wdata);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin step(); n++; end while (!if_valid && !mon_ack && n < 12);
  endtask

  task automatic reset_checks();
    check_eq("rst_sram_ce",    32'(sram_ce),      32'h0);
    check_eq("rst_sram_we",    32'(sram_we),      32'h0);
    check_eq("rst_sram_addr",  32'(sram_addr),    32'h0);
    check_eq("rst_sram_wdata", sram_wdata,        32'h0);
    check_eq("rst_if_valid",   32'(if_valid),     32'h0);
    check_eq("rst_if_instr",   if_instr,          32'h0);
    check_eq("rst_if_stall",   32'(if_stall_req), 32'h0);
    check_eq("rst_mon_ack",    32'(mon_ack),      32'h0);
    check_eq("rst_mon_rdata",  mon_rdata,         32'h0);
  endtask

  task automatic mid_reset();
    for (int k = 0; k < 40 && t != 1; k++) step();
    #2 rst_n = 1'b0;
    #1 reset_checks();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr(input bit low);
    return {16'($urandom), 6'd0, 8'($urandom), low ? 2'($urandom) : 2'b00};
  endfunction

  initial begin
    int n, nv, na, nr;
    if_ce = 1'b1; if_pc = 32'h40;
    mon_req = 1'b0; mon_we = 1'b0; mon_addr = '0; mon_wdata = '0;
    if_ce1 = 1'b0; if_pc1 = 32'h200;
    repeat (3) @(negedge clk);
    #1 reset_checks();

    // Basic fetch straight out of reset
    rst_n = 1'b1;
    n = 0;
    do begin
      step(); n++;
      if (n == 1) check_eq("fetch_addr", 32'(sram_addr), 32'h10);
    end while (!if_valid && n < 12);
    check_eq("fetch_latency", n, 3);
    check_eq("fetch_instr", if_instr, 32'h2402_0005);
    if_ce = 1'b0;

    // Monitor write then read back
    repeat (2) step();
    mon_req = 1'b1; mon_we = 1'b1; mon_addr = 32'h100; mon_wdata = 32'hDEAD_BEEF;
    step();
    check_eq("mon_wr_we",   32'(sram_we),   32'h1);
    check_eq("mon_wr_addr", 32'(sram_addr), 32'h40);
    n = 1;
    while (!mon_ack && n < 12) begin step(); n++; end
    check_eq("mon_wr_latency", n, 3);
    mon_req = 1'b0;
    repeat (2) step();
    mon_req = 1'b1; mon_we = 1'b0;
    wait_resp(n);
    check_eq("mon_rd_latency", n, 3);
    check_eq("mon_rd_data", mon_rdata, 32'hDEAD_BEEF);
    mon_req = 1'b0;

    // Contention: both held, monitor had the last turn so IF goes first
    repeat (2) step();
    mon_req = 1'b1; if_ce = 1'b1; if_pc = 32'h40;
    nv = 0; na = 0; nr = 0;
    repeat (24) begin
      step();
      if (if_valid || mon_ack) begin
        check_eq("contend_order", 32'(mon_ack), 32'(nr % 2));
        nr++;
      end
      nv += int'(if_valid); na += int'(mon_ack);
    end
    check_eq("contend_if_count",  nv, 3);
    check_eq("contend_mon_count", na, 3);
    mon_req = 1'b0; if_ce = 1'b0;

    // Redirect in the middle of a fetch
    repeat (3) step();
    if_ce = 1'b1; if_pc = 32'h40;
    step();
    if_pc = 32'h80;
    n = 1;
    while (!if_valid && n < 14) begin
      step(); n++;
      if (n == 4) check_eq("redirect_addr", 32'(sram_addr), 32'h20);
    end
    check_eq("redirect_latency", n, 6);
    check_eq("redirect_instr", if_instr, init_word(32'h20));

    // Reset during ACC, then a clean fetch
    if_ce = 1'b0;
    repeat (2) step();
    if_ce = 1'b1; if_pc = 32'h60;
    step();
    mid_reset();
    wait_resp(n);
    check_eq("post_reset_latency", n, 3);
    check_eq("post_reset_instr", if_instr, init_word(32'h18));
    if_ce = 1'b0;
    repeat (2) step();

    // LAT=1 instance: back-to-back fetches every 3 cycles
    if_ce1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      check_eq("lat1_ce",    32'(sram_ce1),  32'(k % 3 == 1));
      check_eq("lat1_valid", 32'(if_valid1), 32'(k % 3 == 2));
      check_eq("lat1_stall", 32'(if_stall1), 32'(k % 3 != 2));
      check_eq("lat1_quiet", 32'({sram_we1, mon_ack1}), 32'h0);
      if (sram_ce1) check_eq("lat1_addr", 32'(sram_addr1), 32'(if_pc1[15:2]));
      if (if_valid1) begin
        check_eq("lat1_instr", if_instr1, init_word(int'(if_pc1[15:2])));
        if_pc1 = if_pc1 + 32'd4;
      end
    end
    if_ce1 = 1'b0;

    // Randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) mid_reset();
      if (if_valid) if_pc = (if_pc + 32'd4) & 32'hFFFF_03FC;
      if ($urandom_range(0, 99) < 4) if_pc = rand_addr(1'b0);
      if (if_ce) begin
        if ($urandom_range(0, 99) < 6) if_ce = 1'b0;
      end else if ($urandom_range(0, 99) < 40) if_ce = 1'b1;
      if (mon_req) begin
        if (mon_ack || (t != 0 && m_mon && $urandom_range(0, 99) < 3)) mon_req = 1'b0;
      end else if ($urandom_range(0, 99) < 25) begin
        mon_req   = 1'b1;
        mon_we    = 1'($urandom_range(0, 1));
        mon_addr  = rand_addr(1'b1);
        mon_wdata = $urandom;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
